// File: rtl/hazard_ctrl_pkg.sv
// Shared core definitions for the five-stage ARM pipeline control.
// Holds register-index geometry, the default producer-to-WB depth and
// the ID/EX control word whose all-zero value is the bubble (NOP).
package hazard_ctrl_pkg;

  localparam int unsigned REG_IDX_W      = 4;
  localparam int unsigned NUM_REGS       = 16;
  localparam int unsigned DEF_PIPE_DEPTH = 2;

  localparam logic [REG_IDX_W-1:0] PC_REG = 4'd15;

  // Control word latched into ID/EX; a bubble loads IDEX_NOP.
  typedef struct packed {
    logic       wb_en;
    logic       mem_read;
    logic       mem_write;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } idex_ctrl_t;

  localparam idex_ctrl_t IDEX_NOP = '0;

  // R15 is the PC: it is never tracked as an in-flight destination.
  function automatic logic is_pc_reg(input logic [REG_IDX_W-1:0] r);
    return r == PC_REG;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for in-flight destinations.
// Build option: HAZARD_FORWARD_EN selects load-use-only busy reporting.
// Ports:
//   clk, rst          clock, async active-high reset
//   advance_i         pipeline advances this edge
//   issue_i           ID instruction issues (writes back) this edge
//   dest_i            destination of the issuing instruction
//   mem_read_i        issuing instruction is a load
//   rd1_i, rd2_i      read-port register indices
//   busy1_c_o/2_c_o   combinational busy lookup for each read port
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = DEF_PIPE_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 advance_i,
  input  logic                 issue_i,
  input  logic [REG_IDX_W-1:0] dest_i,
  input  logic                 mem_read_i,
  input  logic [REG_IDX_W-1:0] rd1_i,
  input  logic [REG_IDX_W-1:0] rd2_i,
  output logic                 busy1_c_o,
  output logic                 busy2_c_o
);

  localparam int unsigned CNT_W = $clog2(PIPE_DEPTH + 1);

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] ld_q;
  logic [NUM_REGS-1:0] ld_d;

  // Entry storage; reset clears every pending writer immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        cnt_q[r] <= '0;
      end
      ld_q <= '0;
    end else begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      ld_q <= ld_d;
    end
  end

  // Decrement all live entries, then let a new issue overwrite its entry.
  always_comb begin
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      cnt_d[r] = cnt_q[r];
    end
    ld_d = ld_q;
    if (advance_i) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
      end
      if (issue_i && !is_pc_reg(dest_i)) begin
        cnt_d[dest_i] = CNT_W'(PIPE_DEPTH);
        ld_d[dest_i]  = mem_read_i;
      end
    end
  end

  // With forwarding only a load one edge past issue is unavailable.
  always_comb begin
`ifdef HAZARD_FORWARD_EN
    busy1_c_o = ld_q[rd1_i] && (cnt_q[rd1_i] == CNT_W'(PIPE_DEPTH));
    busy2_c_o = ld_q[rd2_i] && (cnt_q[rd2_i] == CNT_W'(PIPE_DEPTH));
`else
    busy1_c_o = cnt_q[rd1_i] != '0;
    busy2_c_o = cnt_q[rd2_i] != '0;
`endif
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and flush controller: freeze/bubble on RAW hazards,
// one-cycle flush on a taken branch, full stall on memory wait states.
// Build option: HAZARD_FORWARD_EN (EX forwarding present, load-use only).
// Ports:
//   clk, rst                  clock, async active-high reset
//   id_valid, src1, src2,     ID instruction and its source operands
//   src1_valid, src2_valid
//   id_wb_en, id_mem_read,    ID instruction writeback / load / destination
//   id_dest
//   branch_taken              branch resolved taken in EX
//   mem_ready                 data memory completes this cycle
//   freeze_front              hold PC and IF/ID (combinational)
//   bubble                    load NOP into ID/EX (combinational)
//   flush                     clear IF/ID and ID/EX (combinational)
//   stall_all                 hold every pipeline register (combinational)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = DEF_PIPE_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] src1,
  input  logic [REG_IDX_W-1:0] src2,
  input  logic                 src1_valid,
  input  logic                 src2_valid,
  input  logic                 id_wb_en,
  input  logic                 id_mem_read,
  input  logic [REG_IDX_W-1:0] id_dest,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  output logic                 freeze_front,
  output logic                 bubble,
  output logic                 flush,
  output logic                 stall_all
);

  logic busy1_c;
  logic busy2_c;
  logic hazard_c;
  logic issue_c;

  hazard_scoreboard #(
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .advance_i  (mem_ready),
    .issue_i    (issue_c),
    .dest_i     (id_dest),
    .mem_read_i (id_mem_read),
    .rd1_i      (src1),
    .rd2_i      (src2),
    .busy1_c_o  (busy1_c),
    .busy2_c_o  (busy2_c)
  );

  // Hazard detection and issue qualification; a flushed ID never issues.
  always_comb begin
    hazard_c = id_valid & ((src1_valid & busy1_c) | (src2_valid & busy2_c));
    issue_c  = mem_ready & id_valid & id_wb_en & ~hazard_c & ~branch_taken;
  end

  // Priority: memory stall, then branch flush, then hazard bubble.
  always_comb begin
    stall_all    = 1'b0;
    flush        = 1'b0;
    bubble       = 1'b0;
    freeze_front = 1'b0;
    if (!mem_ready) begin
      stall_all = 1'b1;
    end else if (branch_taken) begin
      flush = 1'b1;
    end else if (hazard_c) begin
      bubble       = 1'b1;
      freeze_front = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic against a model that tracks, per register, the global count of
// advancing edges at which its pending write becomes visible.
module tb_hazard_ctrl;

  localparam int unsigned DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] src1;
  logic [3:0] src2;
  logic       src1_valid;
  logic       src2_valid;
  logic       id_wb_en;
  logic       id_mem_read;
  logic [3:0] id_dest;
  logic       branch_taken;
  logic       mem_ready;
  logic       freeze_front;
  logic       bubble;
  logic       flush;
  logic       stall_all;

  hazard_ctrl #(.PIPE_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .src1         (src1),
    .src2         (src2),
    .src1_valid   (src1_valid),
    .src2_valid   (src2_valid),
    .id_wb_en     (id_wb_en),
    .id_mem_read  (id_mem_read),
    .id_dest      (id_dest),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .freeze_front (freeze_front),
    .bubble       (bubble),
    .flush        (flush),
    .stall_all    (stall_all)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: adv_cnt counts advancing edges; a write issued on the edge that
  // makes adv_cnt == n is visible once adv_cnt reaches n + DEPTH.
  int unsigned adv_cnt;
  int unsigned ready_at [16];
  int unsigned issued_at [16];
  bit          was_load [16];
  bit          last_bubble;

  function automatic void model_reset();
    for (int r = 0; r < 16; r++) begin
      ready_at[r]  = 0;
      issued_at[r] = 0;
      was_load[r]  = 0;
    end
  endfunction

  function automatic bit m_busy(input logic [3:0] r);
`ifdef HAZARD_FORWARD_EN
    return was_load[r] && (issued_at[r] == adv_cnt) && (ready_at[r] > adv_cnt);
`else
    return adv_cnt < ready_at[r];
`endif
  endfunction

  function automatic bit m_hazard();
    return id_valid && ((src1_valid && m_busy(src1)) || (src2_valid && m_busy(src2)));
  endfunction

  task automatic drive_idle();
    id_valid = 0; src1 = 0; src2 = 0; src1_valid = 0; src2_valid = 0;
    id_wb_en = 0; id_mem_read = 0; id_dest = 0; branch_taken = 0;
    mem_ready = 1;
  endtask

  // Check all outputs for the current (negedge-driven) inputs, then step.
  task automatic run_cycle(input string tag);
    bit hz;
    bit iss;
    #1;
    hz = m_hazard();
    chk({tag, ".stall_all"},    int'(stall_all),    int'(!mem_ready));
    chk({tag, ".flush"},        int'(flush),        int'(mem_ready && branch_taken));
    chk({tag, ".bubble"},       int'(bubble),       int'(mem_ready && !branch_taken && hz));
    chk({tag, ".freeze_front"}, int'(freeze_front), int'(mem_ready && !branch_taken && hz));
    last_bubble = bubble;
    iss = mem_ready && id_valid && id_wb_en && !hz && !branch_taken;
    @(posedge clk);
    if (mem_ready) begin
      adv_cnt++;
      if (iss && id_dest != 4'd15) begin
        ready_at[id_dest]  = adv_cnt + DEPTH;
        issued_at[id_dest] = adv_cnt;
        was_load[id_dest]  = id_mem_read;
      end
    end
    @(negedge clk);
  endtask

  task automatic issue_write(input logic [3:0] d, input logic ld, input string tag);
    drive_idle();
    id_valid = 1; id_wb_en = 1; id_dest = d; id_mem_read = ld;
    run_cycle(tag);
    drive_idle();
  endtask

  // Hold a reader of rd in ID until it stops bubbling; return bubble count.
  task automatic count_bubbles(input logic [3:0] rd, input bit use_src2,
                               input string tag, output int n);
    n = 0;
    drive_idle();
    id_valid = 1;
    if (use_src2) begin src2 = rd; src2_valid = 1; end
    else          begin src1 = rd; src1_valid = 1; end
    for (int i = 0; i < 6; i++) begin
      run_cycle(tag);
      if (!last_bubble) break;
      n++;
    end
    drive_idle();
  endtask

  int nb;
  int exp_alu;
  int exp_load;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef HAZARD_FORWARD_EN
    exp_alu = 0; exp_load = 1;
`else
    exp_alu = 2; exp_load = 2;
`endif
    adv_cnt = 0;
    model_reset();
    drive_idle();
    rst = 1;
    #2;
    chk("rst.idle_bubble", int'(bubble), 0);
    chk("rst.idle_flush", int'(flush), 0);
    chk("rst.idle_stall", int'(stall_all), 0);
    chk("rst.idle_freeze", int'(freeze_front), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // Reset with a pending entry on R3, then read R3.
    issue_write(4'd3, 1'b1, "rst_pre");
    id_valid = 1; src1 = 3; src1_valid = 1;
    #1;
    chk("rst.pre_bubble", int'(bubble), 1);
    rst = 1;
    model_reset();
    #1;
    chk("rst.async_bubble", int'(bubble), 0);
    chk("rst.async_freeze", int'(freeze_front), 0);
    @(negedge clk);
    rst = 0;
    run_cycle("rst_post");
    chk("rst.post_bubble", int'(last_bubble), 0);
    drive_idle();
    run_cycle("idle");

    // ALU producer then dependent on src1.
    issue_write(4'd2, 1'b0, "alu_prod");
    count_bubbles(4'd2, 1'b0, "alu_dep", nb);
    chk("alu.bubbles", nb, exp_alu);

    // Load producer then dependent on src2.
    issue_write(4'd4, 1'b1, "ld_prod");
    count_bubbles(4'd4, 1'b1, "ld_dep", nb);
    chk("load.bubbles", nb, exp_load);

    // Independent instruction.
    issue_write(4'd8, 1'b1, "ind_prod");
    count_bubbles(4'd9, 1'b0, "ind_dep", nb);
    chk("indep.bubbles", nb, 0);
    run_cycle("drain0");
    run_cycle("drain1");

    // Taken branch while ID has a hazard; flushed ID writes R5.
    issue_write(4'd1, 1'b1, "br_prod");
    id_valid = 1; src1 = 1; src1_valid = 1; id_wb_en = 1; id_dest = 5;
    branch_taken = 1;
    run_cycle("br_haz");
    drive_idle();
    count_bubbles(4'd5, 1'b0, "br_r5", nb);
    chk("branch.r5_not_issued", nb, 0);
    run_cycle("drain2");
    run_cycle("drain3");

    // Memory wait with a branch held in EX and R6 pending.
    issue_write(4'd6, 1'b0, "mw_prod");
    branch_taken = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      run_cycle("mw_stall");
      chk("mw.stall_flush", int'(flush), 0);
    end
    mem_ready = 1;
    #1;
    chk("mw.release_flush", int'(flush), 1);
    run_cycle("mw_release");
    branch_taken = 0;
    #1;
    chk("mw.flush_once", int'(flush), 0);
    count_bubbles(4'd6, 1'b0, "mw_r6", nb);
`ifdef HAZARD_FORWARD_EN
    chk("mw.r6_bubbles", nb, 0);
`else
    chk("mw.r6_bubbles", nb, 1);
`endif

    // R15 is never busy.
    issue_write(4'd15, 1'b1, "r15_prod");
    count_bubbles(4'd15, 1'b0, "r15_dep", nb);
    chk("r15.bubbles", nb, 0);

    // Back-to-back writers to R7: the second reloads the countdown.
    issue_write(4'd7, 1'b0, "ow_a");
    issue_write(4'd7, 1'b0, "ow_b");
    count_bubbles(4'd7, 1'b0, "ow_dep", nb);
    chk("overwrite.bubbles", nb, exp_alu);

    // Randomized traffic on a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      id_valid     = ($urandom_range(0, 9) != 0);
      src1         = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      src2         = 4'($urandom_range(0, 3));
      src1_valid   = 1'($urandom);
      src2_valid   = 1'($urandom);
      id_wb_en     = ($urandom_range(0, 3) != 0);
      id_mem_read  = 1'($urandom);
      id_dest      = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_ready    = ($urandom_range(0, 4) != 0);
      run_cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
